// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU opcode encodings and multi-cycle FSM state type.
// ALU opcodes start at 1 so that the all-zero code is reserved for
// "illegal / no operation". Divide-class ops need the multi-cycle unit.
package riscv_pkg;
  localparam int ALUOP_WIDTH = 5;

  localparam logic [ALUOP_WIDTH-1:0] ADD_OP     = 5'd1;
  localparam logic [ALUOP_WIDTH-1:0] SUB_OP     = 5'd2;
  localparam logic [ALUOP_WIDTH-1:0] PASS_OP    = 5'd3;
  localparam logic [ALUOP_WIDTH-1:0] SLL_OP     = 5'd4;
  localparam logic [ALUOP_WIDTH-1:0] SLT_OP     = 5'd5;
  localparam logic [ALUOP_WIDTH-1:0] SLTU_OP    = 5'd6;
  localparam logic [ALUOP_WIDTH-1:0] XOR_OP     = 5'd7;
  localparam logic [ALUOP_WIDTH-1:0] OR_OP      = 5'd8;
  localparam logic [ALUOP_WIDTH-1:0] AND_OP     = 5'd9;
  localparam logic [ALUOP_WIDTH-1:0] SRL_OP     = 5'd10;
  localparam logic [ALUOP_WIDTH-1:0] SRA_OP     = 5'd11;
  localparam logic [ALUOP_WIDTH-1:0] LOTOUPC_OP = 5'd12;
  localparam logic [ALUOP_WIDTH-1:0] MUL_OP     = 5'd13;
  localparam logic [ALUOP_WIDTH-1:0] MULH_OP    = 5'd14;
  localparam logic [ALUOP_WIDTH-1:0] MULHSU_OP  = 5'd15;
  localparam logic [ALUOP_WIDTH-1:0] MULHU_OP   = 5'd16;
  localparam logic [ALUOP_WIDTH-1:0] DIV_OP     = 5'd17;
  localparam logic [ALUOP_WIDTH-1:0] DIVU_OP    = 5'd18;
  localparam logic [ALUOP_WIDTH-1:0] REM_OP     = 5'd19;
  localparam logic [ALUOP_WIDTH-1:0] REMU_OP    = 5'd20;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;

  // Ops that must be handed to the multi-cycle divide unit.
  function automatic logic is_mc_op(input logic [ALUOP_WIDTH-1:0] op);
    return (op == DIV_OP) || (op == DIVU_OP) || (op == REM_OP) || (op == REMU_OP);
  endfunction
endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: decode-side request and execute-side response bundle.
//   i_*  : op fields, valid, hart tag, stall, multi-cycle done (to DUT)
//   o_*  : decoded op, valid, hart tag, illegal flag/count, mc handshake
// slave modport is used by the pipe, master by its driver.
interface alu_ctrl_pipe_if #(
  parameter int HART_ID_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
);
  logic                                i_valid;
  logic [HART_ID_WIDTH-1:0]            i_hart_id;
  logic [2:0]                          i_ALUctrl;
  logic [2:0]                          i_funct3;
  logic [6:0]                          i_funct7;
  logic                                i_is_imm;
  logic                                i_stall;
  logic                                i_mc_done;
  logic [riscv_pkg::ALUOP_WIDTH-1:0]   o_ALUOp;
  logic                                o_valid;
  logic [HART_ID_WIDTH-1:0]            o_hart_id;
  logic                                o_illegal;
  logic [CNT_WIDTH-1:0]                o_illegal_cnt;
  logic                                o_mc_start;
  logic                                o_mc_busy;

  modport slave (
    input  i_valid, i_hart_id, i_ALUctrl, i_funct3, i_funct7, i_is_imm,
           i_stall, i_mc_done,
    output o_ALUOp, o_valid, o_hart_id, o_illegal, o_illegal_cnt,
           o_mc_start, o_mc_busy
  );

  modport master (
    output i_valid, i_hart_id, i_ALUctrl, i_funct3, i_funct7, i_is_imm,
           i_stall, i_mc_done,
    input  o_ALUOp, o_valid, o_hart_id, o_illegal, o_illegal_cnt,
           o_mc_start, o_mc_busy
  );
endinterface

// File: rtl/alu_ctrl_pipe_decode.sv
// alu_op_decode: combinational ALU-op decoder.
//   i_ALUctrl/i_funct3/i_funct7/i_is_imm -> o_op, o_illegal
// Illegal encodings produce o_op='0; o_illegal is derived from that since
// every legal opcode is non-zero.
// Build option: RV32M_EN enables the M-extension encodings.
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic [2:0]             i_ALUctrl,
  input  logic [2:0]             i_funct3,
  input  logic [6:0]             i_funct7,
  input  logic                   i_is_imm,
  output logic [ALUOP_WIDTH-1:0] o_op,
  output logic                   o_illegal
);
  logic w_f7_zero, w_f7_alt, w_f7_one, w_mext, w_imm_or_f7z;

  assign w_f7_zero    = (i_funct7 == 7'b0000000);
  assign w_f7_alt     = (i_funct7 == 7'b0100000);
  assign w_f7_one     = (i_funct7 == 7'b0000001);
  assign w_imm_or_f7z = i_is_imm | w_f7_zero;
`ifdef RV32M_EN
  assign w_mext = w_f7_one & ~i_is_imm;
`else
  assign w_mext = 1'b0;
`endif

  always_comb begin
    o_op = '0;
    case (i_ALUctrl)
      3'b000: o_op = ADD_OP;
      3'b001: o_op = SUB_OP;
      3'b011: o_op = PASS_OP;
      3'b010: begin
        if (w_mext) begin
          case (i_funct3)
            3'b000:  o_op = MUL_OP;
            3'b001:  o_op = MULH_OP;
            3'b010:  o_op = MULHSU_OP;
            3'b011:  o_op = MULHU_OP;
            3'b100:  o_op = DIV_OP;
            3'b101:  o_op = DIVU_OP;
            3'b110:  o_op = REM_OP;
            default: o_op = REMU_OP;
          endcase
        end else begin
          case (i_funct3)
            // SUB is never produced here: funct7=0100000 on a reg-reg
            // ADD slot is treated as illegal.
            3'b000:  o_op = w_imm_or_f7z ? ADD_OP  : '0;
            3'b001:  o_op = w_f7_zero    ? SLL_OP  : '0;
            3'b010:  o_op = w_imm_or_f7z ? SLT_OP  : '0;
            3'b011:  o_op = w_imm_or_f7z ? SLTU_OP : '0;
            3'b100:  o_op = w_imm_or_f7z ? XOR_OP  : '0;
            3'b110:  o_op = w_imm_or_f7z ? OR_OP   : '0;
            3'b111:  o_op = w_imm_or_f7z ? AND_OP  : '0;
            default: o_op = w_f7_zero ? SRL_OP : (w_f7_alt ? SRA_OP : '0);
          endcase
        end
      end
      3'b100: o_op = (i_funct3 == 3'b000 && w_f7_one && !i_is_imm) ? LOTOUPC_OP : '0;
      default: o_op = '0;
    endcase
  end

  assign o_illegal = (o_op == '0);
endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: PIPE_DEPTH-stage registered ALU-op decode pipe.
//   clk, reset (async, active high)
//   bus (alu_ctrl_pipe_if.slave): op in / decoded op out, stall,
//     saturating illegal-op counter, multi-cycle start/busy/done.
// Build option: RV32M_EN adds M-extension decode and the IDLE/BUSY
// divide sequencer; without it o_mc_start/o_mc_busy are tied low.
// PIPE_DEPTH is legal in 1..4.
module alu_ctrl_pipe
  import riscv_pkg::*;
#(
  parameter int PIPE_DEPTH    = 1,
  parameter int HART_ID_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input logic            clk,
  input logic            reset,
  alu_ctrl_pipe_if.slave bus
);
  logic [ALUOP_WIDTH-1:0]                     w_dec_op;
  logic                                       w_dec_illegal;
  logic                                       w_adv, w_mc_busy, w_mc_start;
  logic [PIPE_DEPTH:1]                        r_vld_pipe;
  logic [PIPE_DEPTH:1]                        r_ill_pipe;
  logic [PIPE_DEPTH:1][ALUOP_WIDTH-1:0]       r_op_pipe;
  logic [PIPE_DEPTH:1][HART_ID_WIDTH-1:0]     r_hart_pipe;
  logic [CNT_WIDTH-1:0]                       r_cnt;

  alu_op_decode u_dec (
    .i_ALUctrl (bus.i_ALUctrl),
    .i_funct3  (bus.i_funct3),
    .i_funct7  (bus.i_funct7),
    .i_is_imm  (bus.i_is_imm),
    .o_op      (w_dec_op),
    .o_illegal (w_dec_illegal)
  );

  assign w_adv = ~bus.i_stall & ~w_mc_busy;

  // Illegal is folded with valid at entry so a bubble never reports it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe  <= '0;
      r_ill_pipe  <= '0;
      r_op_pipe   <= '0;
      r_hart_pipe <= '0;
    end else if (w_adv) begin
      r_vld_pipe[1]  <= bus.i_valid;
      r_ill_pipe[1]  <= bus.i_valid & w_dec_illegal;
      r_op_pipe[1]   <= w_dec_op;
      r_hart_pipe[1] <= bus.i_hart_id;
      for (int s = 2; s <= PIPE_DEPTH; s++) begin
        r_vld_pipe[s]  <= r_vld_pipe[s-1];
        r_ill_pipe[s]  <= r_ill_pipe[s-1];
        r_op_pipe[s]   <= r_op_pipe[s-1];
        r_hart_pipe[s] <= r_hart_pipe[s-1];
      end
    end
  end

  // Counts an illegal op as it leaves the output stage; sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_adv && r_vld_pipe[PIPE_DEPTH] && r_ill_pipe[PIPE_DEPTH] && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

`ifdef RV32M_EN
  mc_state_t r_state, w_state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // The divide is handed off as it advances out of the output stage;
  // the pipe then freezes until the unit reports done.
  always_comb begin
    w_state_nxt = r_state;
    w_mc_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_vld_pipe[PIPE_DEPTH] && is_mc_op(r_op_pipe[PIPE_DEPTH]) && !bus.i_stall) begin
          w_mc_start  = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY:    if (bus.i_mc_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_mc_busy = (r_state == BUSY);
`else
  logic w_unused_mc_done;
  assign w_unused_mc_done = bus.i_mc_done;
  assign w_mc_start       = 1'b0;
  assign w_mc_busy        = 1'b0;
`endif

  assign bus.o_valid       = r_vld_pipe[PIPE_DEPTH];
  assign bus.o_illegal     = r_ill_pipe[PIPE_DEPTH];
  assign bus.o_ALUOp       = r_op_pipe[PIPE_DEPTH];
  assign bus.o_hart_id     = r_hart_pipe[PIPE_DEPTH];
  assign bus.o_illegal_cnt = r_cnt;
  assign bus.o_mc_start    = w_mc_start;
  assign bus.o_mc_busy     = w_mc_busy;
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;
  import riscv_pkg::*;

  localparam int PD = 2;
  localparam int HW = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [ALUOP_WIDTH-1:0] op;
    logic                   ill;
    logic [HW-1:0]          hart;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_pipe_if #(.HART_ID_WIDTH(HW), .CNT_WIDTH(CW)) bus ();

  alu_ctrl_pipe #(.PIPE_DEPTH(PD), .HART_ID_WIDTH(HW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  // Scoreboard: an op is retired on the edge where it sits valid in the
  // output stage and the pipe advances.
  always @(negedge clk) begin
    if (!reset && bus.o_valid && !bus.i_stall && !bus.o_mc_busy) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $error("FAIL sb_extra: got op=%0d ill=%0b hart=%0d expected no op",
               bus.o_ALUOp, bus.o_illegal, bus.o_hart_id);
      end else begin
        mon_e = sb.pop_front();
        assert ({bus.o_ALUOp, bus.o_illegal, bus.o_hart_id} === mon_e) else begin
          n_fail++;
          $error("FAIL sb_out: got op=%0d ill=%0b hart=%0d expected op=%0d ill=%0b hart=%0d",
                 bus.o_ALUOp, bus.o_illegal, bus.o_hart_id, mon_e.op, mon_e.ill, mon_e.hart);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one op, hold it until an advancing edge samples it.
  task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                      input logic imm, input logic [HW-1:0] h,
                      input logic [ALUOP_WIDTH-1:0] eop, input logic eill);
    bit ok;
    ok = 0;
    bus.i_valid = 1'b1; bus.i_ALUctrl = c; bus.i_funct3 = f3;
    bus.i_funct7 = f7;  bus.i_is_imm = imm; bus.i_hart_id = h;
    sb.push_back('{eop, eill, h});
    if (eill && exp_cnt < 15) exp_cnt++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.i_stall && !bus.o_mc_busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $error("FAIL send_timeout: got stalled expected advance");
    end
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, bus.o_valid, 0);
    chk({tag, "_op"},    bus.o_ALUOp, 0);
    chk({tag, "_ill"},   bus.o_illegal, 0);
    chk({tag, "_hart"},  bus.o_hart_id, 0);
    chk({tag, "_cnt"},   bus.o_illegal_cnt, 0);
    chk({tag, "_start"}, bus.o_mc_start, 0);
    chk({tag, "_busy"},  bus.o_mc_busy, 0);
  endtask

  initial begin
    bit ok;
    logic [ALUOP_WIDTH-1:0] mul_op;
    logic                   mul_ill;
`ifdef RV32M_EN
    mul_op = MUL_OP; mul_ill = 1'b0;
`else
    mul_op = '0;     mul_ill = 1'b1;
`endif
    reset = 1'b1;
    bus.i_valid = 0; bus.i_hart_id = 0; bus.i_ALUctrl = 0; bus.i_funct3 = 0;
    bus.i_funct7 = 0; bus.i_is_imm = 0; bus.i_stall = 0; bus.i_mc_done = 0;
    step(); step();
    chk_zero_outputs("reset");
    reset = 1'b0;
    step();

    // Latency: SRA sampled on edge E0 must be visible from E1 onwards.
    send(3'b010, 3'b101, 7'b0100000, 1'b0, 4'd3, SRA_OP, 1'b0);
    chk("lat_early_valid", bus.o_valid, 0);
    step();
    chk("lat_valid", bus.o_valid, 1);
    chk("lat_op",    bus.o_ALUOp, SRA_OP);
    chk("lat_hart",  bus.o_hart_id, 3);
    drain();

    // ADD slot with funct7=0100000: ADDI is legal, reg-reg is not.
    send(3'b010, 3'b000, 7'b0100000, 1'b1, 4'd1, ADD_OP, 1'b0);
    drain();
    chk("cnt_before_ill", bus.o_illegal_cnt, 0);
    send(3'b010, 3'b000, 7'b0100000, 1'b0, 4'd2, '0, 1'b1);
    drain();
    chk("cnt_after_ill", bus.o_illegal_cnt, 1);

    // Back-to-back decode table.
    send(3'b000, 3'b111, 7'b1111111, 1'b0, 4'd4,  ADD_OP,     1'b0);
    send(3'b001, 3'b000, 7'b0000000, 1'b0, 4'd5,  SUB_OP,     1'b0);
    send(3'b011, 3'b010, 7'b0000000, 1'b0, 4'd6,  PASS_OP,    1'b0);
    send(3'b010, 3'b001, 7'b0000000, 1'b1, 4'd7,  SLL_OP,     1'b0);
    send(3'b010, 3'b001, 7'b0100000, 1'b1, 4'd8,  '0,         1'b1);
    send(3'b010, 3'b010, 7'b1010101, 1'b1, 4'd9,  SLT_OP,     1'b0);
    send(3'b010, 3'b011, 7'b0000000, 1'b0, 4'd10, SLTU_OP,    1'b0);
    send(3'b010, 3'b100, 7'b0000000, 1'b0, 4'd11, XOR_OP,     1'b0);
    send(3'b010, 3'b100, 7'b0100000, 1'b0, 4'd11, '0,         1'b1);
    send(3'b010, 3'b110, 7'b1111111, 1'b1, 4'd12, OR_OP,      1'b0);
    send(3'b010, 3'b111, 7'b0000000, 1'b0, 4'd13, AND_OP,     1'b0);
    send(3'b010, 3'b101, 7'b0000000, 1'b1, 4'd14, SRL_OP,     1'b0);
    send(3'b010, 3'b101, 7'b0000010, 1'b0, 4'd15, '0,         1'b1);
    send(3'b100, 3'b000, 7'b0000001, 1'b0, 4'd1,  LOTOUPC_OP, 1'b0);
    send(3'b100, 3'b000, 7'b0000001, 1'b1, 4'd2,  '0,         1'b1);
    send(3'b101, 3'b000, 7'b0000000, 1'b0, 4'd3,  '0,         1'b1);
    send(3'b111, 3'b000, 7'b0000000, 1'b0, 4'd4,  '0,         1'b1);
    send(3'b010, 3'b000, 7'b0000001, 1'b0, 4'd5,  mul_op,     mul_ill);
    drain();
    chk("cnt_table", bus.o_illegal_cnt, exp_cnt);

    // Stall with two ops in flight; head op is illegal so a leaking
    // counter would show up.
    send(3'b010, 3'b000, 7'b0100000, 1'b0, 4'd6, '0,     1'b1);
    send(3'b000, 3'b000, 7'b0000000, 1'b0, 4'd7, ADD_OP, 1'b0);
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", bus.o_valid, 1);
      chk("stall_ill",   bus.o_illegal, 1);
      chk("stall_hart",  bus.o_hart_id, 6);
      chk("stall_cnt",   bus.o_illegal_cnt, exp_cnt - 1);
    end
    bus.i_stall = 1'b0;
    drain();
    chk("cnt_after_stall", bus.o_illegal_cnt, exp_cnt);

    // Saturation: 17 more illegal ops; wrapping would land below 15.
    for (int i = 0; i < 17; i++)
      send(3'b110, 3'(i), 7'b0000000, 1'b0, 4'(i), '0, 1'b1);
    drain();
    chk("cnt_saturate", bus.o_illegal_cnt, 15);

`ifdef RV32M_EN
    // DIV then ADD: start pulses once, busy holds the ADD until done.
    send(3'b010, 3'b100, 7'b0000001, 1'b0, 4'd8, DIV_OP, 1'b0);
    send(3'b000, 3'b000, 7'b0000000, 1'b0, 4'd9, ADD_OP, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_mc_start) begin ok = 1; break; end
    end
    chk("mc_start_seen", ok, 1);
    chk("mc_start_notbusy", bus.o_mc_busy, 0);
    step();
    chk("mc_start_pulse", bus.o_mc_start, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mc_busy",       bus.o_mc_busy, 1);
      chk("mc_busy_hold",  bus.o_ALUOp, ADD_OP);
      step();
    end
    bus.i_mc_done = 1'b1;
    step();
    bus.i_mc_done = 1'b0;
    chk("mc_idle",        bus.o_mc_busy, 0);
    chk("mc_add_valid",   bus.o_valid, 1);
    chk("mc_add_op",      bus.o_ALUOp, ADD_OP);
    chk("mc_add_nostart", bus.o_mc_start, 0);
    drain();
    bus.i_mc_done = 1'b1;
    step();
    bus.i_mc_done = 1'b0;
    step();
    chk("mc_done_idle_ignored", bus.o_mc_busy, 0);

    // Get busy again with an op queued, then reset mid-flight.
    send(3'b010, 3'b110, 7'b0000001, 1'b0, 4'd10, REM_OP, 1'b0);
    send(3'b000, 3'b000, 7'b0000000, 1'b0, 4'd11, ADD_OP, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_mc_start) begin ok = 1; break; end
    end
    chk("mc2_start_seen", ok, 1);
    step();
    chk("mc2_busy", bus.o_mc_busy, 1);
`else
    send(3'b010, 3'b000, 7'b0100000, 1'b0, 4'd10, '0,     1'b1);
    send(3'b000, 3'b000, 7'b0000000, 1'b0, 4'd11, ADD_OP, 1'b0);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    sb.delete();
    exp_cnt = 0;
    step();
    reset = 1'b0;
    step();
    send(3'b011, 3'b000, 7'b0000000, 1'b0, 4'd12, PASS_OP, 1'b0);
    drain();
    chk("post_rst_cnt", bus.o_illegal_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Parametrised, pipelined successor to the single-cycle ALU-op decoder. It maps `i_ALUctrl`/`i_funct3`/`i_funct7` plus an immediate flag to an `ALUOP_WIDTH` opcode through a configurable-depth registered pipeline. The pipeline carries valid, a hart tag, and an illegal-op flag, and honours a stall. It sits between the barrel core's decode and execute stages. It adds I-type-aware decode, illegal-op counting, and optional RV32M multi-cycle sequencing.

## Interface
Parameters:
- `PIPE_DEPTH`, default 1: number of register stages, legal range 1..4.
- `HART_ID_WIDTH`, default 4: width of the hart tag carried alongside each op.
- `CNT_WIDTH`, default 16: width of the illegal-op counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `i_valid`  in  1: input op is valid.
- `i_hart_id`  in  `HART_ID_WIDTH`: issuing hart tag.
- `i_ALUctrl`  in  3: main-decoder ALU class.
- `i_funct3`  in  3: instruction funct3.
- `i_funct7`  in  7: instruction funct7.
- `i_is_imm`  in  1: 1 for OP-IMM encoding.
- `i_stall`  in  1: freeze all stages.
- `o_ALUOp`  out  `ALUOP_WIDTH`: decoded ALU opcode.
- `o_valid`  out  1: output stage holds a valid op.
- `o_hart_id`  out  `HART_ID_WIDTH`: hart tag of the output op.
- `o_illegal`  out  1: output op is undefined.
- `o_illegal_cnt`  out  `CNT_WIDTH`: saturating count of illegal ops.
- `o_mc_start`, `o_mc_busy`  out  1 each: multi-cycle handshake outputs (`RV32M_EN` only).
- `i_mc_done`  in  1: multi-cycle unit completion (`RV32M_EN` only).

## Operation
Decode rules:
- `i_ALUctrl` 000 decodes to ADD_OP; 001 to SUB_OP; 011 to PASS_OP.
- `i_ALUctrl` 010 decodes by `i_funct3`:
  - 000: ADD_OP if `i_is_imm`=1 or `i_funct7`=0000000; otherwise illegal. SUB is never decoded here.
  - 001: SLL_OP. Requires `i_funct7`=0000000; otherwise illegal.
  - 010: SLT_OP. 011: SLTU_OP. 100: XOR_OP. 110: OR_OP. 111: AND_OP. These ignore `i_funct7` when `i_is_imm`=1.
  - 101: `i_funct7` 0000000 gives SRL_OP; 0100000 gives SRA_OP; anything else is illegal.
- `i_ALUctrl` 100 (custom-0): funct3 000 with funct7 0000001 and `i_is_imm`=0 decodes to LOTOUPC_OP; anything else is illegal.
- `i_ALUctrl` 101..111 are illegal.
- Any illegal op outputs `o_ALUOp`='0 with `o_illegal`=1.
- `o_illegal` and `o_ALUOp` are qualified by `o_valid`. When `i_valid`=0, a bubble enters the pipe: valid=0 and payload is don't-care.

Counter:
- `o_illegal_cnt` increments once per cycle in which `o_valid`&`o_illegal` is set and the pipe advances.
- It saturates at all-ones and never wraps.

Reset:
- Every output and every stage register resets to 0, and the FSM resets to IDLE.
- Reset mid-operation discards in-flight ops and clears the counter.

## Timing
- Latency is exactly `PIPE_DEPTH` cycles from input sampling to output, with no combinational input-to-output path.
- Advance condition: `adv` = !`i_stall` & !`o_mc_busy`.
- When `adv`=0, every stage and the counter hold their value, and the input is not sampled; the upstream stage must hold its inputs.
- Throughput is one op per cycle while `adv`=1.

## Configuration
`RV32M_EN` defined:
- `i_ALUctrl` 010 with `i_funct7`=0000001 and `i_is_imm`=0 decodes `i_funct3` 000..111 to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU _OP.
- FSM with states IDLE and BUSY:
  - In IDLE, when the output stage holds a valid DIV/DIVU/REM/REMU and `i_stall`=0, `o_mc_start` pulses for 1 cycle and the FSM moves to BUSY on the next edge.
  - In BUSY, `o_mc_busy`=1 and the pipe is frozen. `i_mc_done`=1 returns the FSM to IDLE at the next edge.
  - `i_mc_done` in IDLE is ignored.
  - A second divide queued behind the first pulses `o_mc_start` on the first IDLE cycle after BUSY.
  - MUL ops are single-cycle, with no start pulse.

`RV32M_EN` not defined:
- Those encodings are illegal.
- `o_mc_start` and `o_mc_busy` are tied to 0, and `i_mc_done` is unused.

## Structure
- Shared `riscv_pkg` holds `ALUOP_WIDTH`, every *_OP constant (including MUL..REMU_OP), and the `mc_state_t` enum {IDLE, BUSY}.
- Combinational sub-module `alu_op_decode` takes ctrl/funct3/funct7/is_imm and produces op and illegal. It feeds stage 1. The stage registers, counter and FSM live in `alu_ctrl_pipe`.

## Test plan
- PIPE_DEPTH=2; issue ctrl=010, f3=101, f7=0100000, valid=1 at cycle 0 -> at cycle 2, `o_ALUOp`=SRA_OP, `o_valid`=1, `o_illegal`=0, `o_hart_id` echoed.
- ctrl=010, f3=000, f7=0100000: with is_imm=1 -> ADD_OP; with is_imm=0 -> `o_ALUOp`=0, `o_illegal`=1, counter increments 0->1.
- Assert `i_stall` for 3 cycles with 2 ops in flight -> outputs frozen; no loss or duplication after release.
- CNT_WIDTH=4; send 17 illegal ops -> `o_illegal_cnt` stops at 15.
- `RV32M_EN`; send DIV then ADD -> 1-cycle `o_mc_start`, `o_mc_busy`=1 until `i_mc_done`; ADD emerges the cycle after IDLE is re-entered.
- Assert `reset` while busy with ops in flight -> all outputs 0 immediately, FSM in IDLE, counter 0.
